// File: rtl/myled_pwm_driver_if.sv
// Configuration bundle from the myled_controller register file to the LED PWM driver.
// The register file is the master; the driver samples the bundle as the slave.
interface myled_pwm_driver_if;
  logic [31:0] ctrl_reg;
  logic [31:0] pattern_reg;
  logic [31:0] duty_reg;
  logic [31:0] period_reg;
  logic        cfg_update;

  modport master (output ctrl_reg, pattern_reg, duty_reg, period_reg, cfg_update);
  modport slave  (input  ctrl_reg, pattern_reg, duty_reg, period_reg, cfg_update);
endinterface

// File: rtl/myled_pwm_driver.sv
// LED output stage: shadowed configuration, prescaled PWM dimming and blink/rotate stepping.
// Configuration changes take effect only on frame boundaries, so a frame is never torn.
module myled_pwm_driver #(
  parameter int NUM_LEDS       = 8,
  parameter int PWM_BITS       = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  myled_pwm_driver_if.slave   cfg,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                step_tick,
  output logic [1:0]          state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, STATIC = 2'd1, BLINK = 2'd2, ROTATE = 2'd3} state_e;

  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

  // Zero counts are treated as one, so the terminal count of a zero setting is zero.
  function automatic logic [PRESCALE_WIDTH-1:0] pre_last(input logic [PRESCALE_WIDTH-1:0] p);
    return (p == '0) ? '0 : p - PRESCALE_WIDTH'(1);
  endfunction

  function automatic logic [15:0] step_last(input logic [15:0] s);
    return (s == '0) ? '0 : s - 16'(1);
  endfunction

  function automatic state_e decode(input logic [2:0] c);
    state_e s;
    if (!c[0])              s = IDLE;
    else if (c[2:1] == 2'b00) s = STATIC;
    else if (c[2:1] == 2'b01) s = BLINK;
    else                    s = ROTATE;
    return s;
  endfunction

  state_e                    state_q, state_d;
  logic [1:0]                sh_mode_q, sh_mode_d;
  logic [NUM_LEDS-1:0]       sh_pat_q, sh_pat_d;
  logic [PWM_BITS-1:0]       sh_duty_q, sh_duty_d;
  logic [PRESCALE_WIDTH-1:0] sh_pre_q, sh_pre_d;
  logic [15:0]               sh_steps_q, sh_steps_d;
  logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [15:0]               step_cnt_q, step_cnt_d;
  logic                      pending_q, pending_d;
  logic                      phase_q, phase_d;
  logic [NUM_LEDS-1:0]       work_q, work_d;
  logic [NUM_LEDS-1:0]       led_q, led_d;
  logic                      step_tick_q, step_tick_d;

  logic pwm_tick, frame_end, pwm_on, load, step;
  logic unused_cfg_bits;

  assign unused_cfg_bits = ^{cfg.ctrl_reg, cfg.pattern_reg, cfg.duty_reg, cfg.period_reg};

  always_comb begin
    pwm_tick  = (state_q != IDLE) && (pre_cnt_q == pre_last(sh_pre_q));
    frame_end = pwm_tick && (pwm_cnt_q == PWM_MAX);
    pwm_on    = (pwm_cnt_q < sh_duty_q) || (sh_duty_q == PWM_MAX);
    load      = (state_q == IDLE) ? pending_q
                                  : (frame_end && (pending_q || cfg.cfg_update));
    step      = frame_end && !load && (step_cnt_q == step_last(sh_steps_q)) &&
                ((state_q == BLINK) || (state_q == ROTATE));

    state_d    = state_q;
    sh_mode_d  = sh_mode_q;
    sh_pat_d   = sh_pat_q;
    sh_duty_d  = sh_duty_q;
    sh_pre_d   = sh_pre_q;
    sh_steps_d = sh_steps_q;
    phase_d    = phase_q;
    work_d     = work_q;
    pending_d  = pending_q | cfg.cfg_update;

    // IDLE parks the counters so a run always begins on a clean frame.
    if (state_q == IDLE) begin
      pre_cnt_d  = '0;
      pwm_cnt_d  = '0;
      step_cnt_d = '0;
    end else begin
      pre_cnt_d  = pwm_tick ? '0 : pre_cnt_q + PRESCALE_WIDTH'(1);
      pwm_cnt_d  = pwm_tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
      step_cnt_d = step_cnt_q;
      if (frame_end)
        step_cnt_d = (step_cnt_q == step_last(sh_steps_q)) ? '0 : step_cnt_q + 16'(1);
    end

    if (step) begin
      if (state_q == BLINK)
        phase_d = ~phase_q;
      else if (sh_mode_q[0])
        work_d = {work_q[0], work_q[NUM_LEDS-1:1]};
      else
        work_d = {work_q[NUM_LEDS-2:0], work_q[NUM_LEDS-1]};
    end

    if (load) begin
      sh_mode_d  = cfg.ctrl_reg[2:1];
      sh_pat_d   = cfg.pattern_reg[NUM_LEDS-1:0];
      sh_duty_d  = cfg.duty_reg[PWM_BITS-1:0];
      sh_pre_d   = cfg.period_reg[PRESCALE_WIDTH-1:0];
      sh_steps_d = cfg.period_reg[31:16];
      work_d     = cfg.pattern_reg[NUM_LEDS-1:0];
      phase_d    = 1'b1;
      step_cnt_d = '0;
      pending_d  = 1'b0;
      state_d    = decode(cfg.ctrl_reg[2:0]);
    end

    led_d       = (state_q != IDLE) ? (work_q & {NUM_LEDS{pwm_on}} & {NUM_LEDS{phase_q}})
                                    : '0;
    step_tick_d = step;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      sh_mode_q   <= '0;
      sh_pat_q    <= '0;
      sh_duty_q   <= '0;
      sh_pre_q    <= '0;
      sh_steps_q  <= '0;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      step_cnt_q  <= '0;
      pending_q   <= 1'b0;
      phase_q     <= 1'b0;
      work_q      <= '0;
      led_q       <= '0;
      step_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_mode_q   <= sh_mode_d;
      sh_pat_q    <= sh_pat_d;
      sh_duty_q   <= sh_duty_d;
      sh_pre_q    <= sh_pre_d;
      sh_steps_q  <= sh_steps_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      step_cnt_q  <= step_cnt_d;
      pending_q   <= pending_d;
      phase_q     <= phase_d;
      work_q      <= work_d;
      led_q       <= led_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign led_out   = led_q;
  assign step_tick = step_tick_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_myled_pwm_driver.sv
// Bench for myled_pwm_driver: table of configurations scored against a closed-form LED model,
// plus hand-written mid-frame update, disable and asynchronous-reset sequences.
module tb_myled_pwm_driver;
  logic       aclk = 1'b0;
  logic       aresetn;
  logic [7:0] led_out;
  logic       step_tick;
  logic [1:0] state_o;

  myled_pwm_driver_if cfg_if();

  myled_pwm_driver #(.NUM_LEDS(8), .PWM_BITS(8), .PRESCALE_WIDTH(16)) dut (
    .ACLK      (aclk),
    .ARESETN   (aresetn),
    .cfg       (cfg_if),
    .led_out   (led_out),
    .step_tick (step_tick),
    .state_o   (state_o)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] pattern;
    logic [31:0] duty;
    logic [31:0] period;
    logic [1:0]  exp_state;
    int          ncyc;
  } vec_t;

  typedef struct {
    logic [7:0] led;
    logic       stp;
    int         k;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rot8(input logic [7:0] v, input int n, input bit right);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = right ? {r[0], r[7:1]} : {r[6:0], r[7]};
    return r;
  endfunction

  // Expected LED word and step pulse k samples after the first post-load output.
  function automatic exp_t model(input logic [31:0] ctrl, input logic [31:0] pattern,
                                 input logic [31:0] duty, input logic [31:0] period,
                                 input int k);
    exp_t       e;
    int         pe, se, t, pwm, stepn;
    logic [7:0] pat, dt, l;
    pat = pattern[7:0];
    dt  = duty[7:0];
    pe  = (period[15:0] == 16'd0) ? 1 : int'(period[15:0]);
    se  = (period[31:16] == 16'd0) ? 1 : int'(period[31:16]);
    t     = k / pe;
    pwm   = t % 256;
    stepn = (t / 256) / se;
    e.k   = k;
    e.led = 8'h00;
    e.stp = 1'b0;
    l     = 8'h00;
    if (ctrl[0]) begin
      case (ctrl[2:1])
        2'b00:   l = pat;
        2'b01:   l = (stepn % 2 == 0) ? pat : 8'h00;
        2'b10:   l = rot8(pat, stepn % 8, 1'b0);
        default: l = rot8(pat, stepn % 8, 1'b1);
      endcase
      e.led = ((pwm < int'(dt)) || (dt == 8'hFF)) ? l : 8'h00;
      e.stp = (ctrl[2:1] != 2'b00) && (((k + 1) % (pe * 256 * se)) == 0);
    end
    return e;
  endfunction

  task automatic push_model(input vec_t v, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++)
      sbq.push_back(model(v.ctrl, v.pattern, v.duty, v.period, k));
  endtask

  task automatic drain_one(input string tag);
    exp_t e;
    @(negedge aclk);
    if (sbq.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_scoreboard: queue empty, expected an entry", tag);
    end else begin
      e = sbq.pop_front();
      check($sformatf("%s_led_k%0d", tag, e.k), led_out, e.led);
      check($sformatf("%s_step_k%0d", tag, e.k), step_tick, e.stp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge aclk);
    aresetn = 1'b0;
    cfg_if.cfg_update = 1'b0;
    repeat (2) @(negedge aclk);
    check({tag, "_rst_led"}, led_out, 8'h00);
    check({tag, "_rst_step"}, step_tick, 1'b0);
    check({tag, "_rst_state"}, state_o, 2'd0);
    aresetn = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge just after the load edge.
  task automatic apply_cfg(input string tag, input vec_t v);
    cfg_if.ctrl_reg    = v.ctrl;
    cfg_if.pattern_reg = v.pattern;
    cfg_if.duty_reg    = v.duty;
    cfg_if.period_reg  = v.period;
    cfg_if.cfg_update  = 1'b1;
    @(negedge aclk);
    cfg_if.cfg_update = 1'b0;
    check({tag, "_state_preload"}, state_o, 2'd0);
    @(negedge aclk);
    check({tag, "_state_load"}, state_o, v.exp_state);
  endtask

  vec_t vecs[8];
  vec_t va, vb;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn            = 1'b0;
    cfg_if.ctrl_reg    = '0;
    cfg_if.pattern_reg = '0;
    cfg_if.duty_reg    = '0;
    cfg_if.period_reg  = '0;
    cfg_if.cfg_update  = 1'b0;

    //           ctrl   pattern        duty       period {S,P}            state  cycles
    vecs[0] = '{32'h1, 32'hA5,        32'd128,   {16'd1, 16'd1}, 2'd1,  600};
    vecs[1] = '{32'h3, 32'hFF,        32'd255,   {16'd2, 16'd1}, 2'd2, 2100};
    vecs[2] = '{32'h5, 32'h80,        32'd255,   {16'd1, 16'd0}, 2'd3,  800};
    vecs[3] = '{32'h7, 32'h01,        32'd32,    {16'd1, 16'd3}, 2'd3, 1600};
    vecs[4] = '{32'h1, 32'hFFFFFF3C,  32'h1FF,   {16'd1, 16'd1}, 2'd1,  300};
    vecs[5] = '{32'h1, 32'hFF,        32'd0,     {16'd1, 16'd1}, 2'd1,  300};
    vecs[6] = '{32'h6, 32'hFF,        32'd255,   {16'd1, 16'd1}, 2'd0,   50};
    vecs[7] = '{32'h3, 32'h5A,        32'd64,    {16'd0, 16'd2}, 2'd2, 1100};

    for (int i = 0; i < 8; i++) begin
      do_reset($sformatf("v%0d", i));
      apply_cfg($sformatf("v%0d", i), vecs[i]);
      push_model(vecs[i], 0, vecs[i].ncyc);
      for (int j = 0; j < vecs[i].ncyc; j++) drain_one($sformatf("v%0d", i));
    end

    // Rotate-right run, new duty/pattern written mid-frame 1; applies at the end of frame 1.
    va = '{32'h7, 32'h01, 32'd128, {16'd1, 16'd1}, 2'd3, 512};
    vb = '{32'h7, 32'h0F, 32'd32,  {16'd1, 16'd1}, 2'd3, 800};
    do_reset("mid");
    apply_cfg("mid", va);
    push_model(va, 0, 512);
    sbq[511].stp = 1'b0;
    push_model(vb, 0, 800);
    for (int j = 0; j < 1312; j++) begin
      drain_one("mid");
      if (j == 356) begin
        cfg_if.ctrl_reg    = vb.ctrl;
        cfg_if.pattern_reg = vb.pattern;
        cfg_if.duty_reg    = vb.duty;
        cfg_if.period_reg  = vb.period;
        cfg_if.cfg_update  = 1'b1;
      end else if (j == 357) begin
        cfg_if.cfg_update = 1'b0;
      end
    end
    check("mid_state_after", state_o, 2'd3);

    // Blink disabled mid-frame: outputs drop right after the next frame_end.
    va = '{32'h3, 32'hFF, 32'd255, {16'd1, 16'd1}, 2'd2, 256};
    vb = '{32'h0, 32'hFF, 32'd255, {16'd1, 16'd1}, 2'd0, 64};
    do_reset("dis");
    apply_cfg("dis", va);
    push_model(va, 0, 256);
    sbq[255].stp = 1'b0;
    push_model(vb, 256, 64);
    for (int j = 0; j < 320; j++) begin
      drain_one("dis");
      if (j == 100) begin
        cfg_if.ctrl_reg   = 32'h0;
        cfg_if.cfg_update = 1'b1;
      end else if (j == 101) begin
        cfg_if.cfg_update = 1'b0;
      end
      if (j == 254) check("dis_state_before", state_o, 2'd2);
      if (j == 255) check("dis_state_after", state_o, 2'd0);
      if (j == 256) check("dis_led_after", led_out, 8'h00);
    end

    // Asynchronous reset in the middle of a rotation, then remain idle until reconfigured.
    va = '{32'h5, 32'h80, 32'd255, {16'd1, 16'd1}, 2'd3, 600};
    do_reset("arst");
    apply_cfg("arst", va);
    push_model(va, 0, 600);
    for (int j = 0; j < 600; j++) drain_one("arst");
    @(posedge aclk);
    #1;
    check("arst_led_before", led_out, 8'h02);
    #1;
    aresetn = 1'b0;
    #1;
    check("arst_led_async", led_out, 8'h00);
    check("arst_step_async", step_tick, 1'b0);
    check("arst_state_async", state_o, 2'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge aclk);
      check($sformatf("arst_idle_state_%0d", j), state_o, 2'd0);
      check($sformatf("arst_idle_led_%0d", j), led_out, 8'h00);
    end
    apply_cfg("arst_re", vecs[0]);
    push_model(vecs[0], 0, 300);
    for (int j = 0; j < 300; j++) drain_one("arst_re");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/myled_pwm_driver.md
Name: myled_pwm_driver

Overview:
- Downstream output stage of the myled_controller AXI4-Lite peripheral.
- Consumes the four slave registers (control, pattern, duty, period) and drives the physical LED pins.
- Supports static, blink, rotate-left and rotate-right modes, with per-frame PWM dimming.
- Register writes are shadowed and applied only at PWM frame boundaries, so the LEDs never show a partial update.

Parameters:
- NUM_LEDS, 8, number of LED outputs (2..32).
- PWM_BITS, 8, PWM counter width; a frame is 2^PWM_BITS pwm ticks.
- PRESCALE_WIDTH, 16, width of the ACLK-to-pwm-tick prescaler.

Ports:
- ACLK  in  1  single clock for the block.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- ctrl_reg  in  32  [0] enable; [2:1] mode: 00 static, 01 blink, 10 rotate-left, 11 rotate-right.
- pattern_reg  in  32  [NUM_LEDS-1:0] LED pattern.
- duty_reg  in  32  [PWM_BITS-1:0] duty; [31:PWM_BITS] ignored.
- period_reg  in  32  [PRESCALE_WIDTH-1:0] prescale P in ACLK cycles; [31:16] steps S in frames per blink/rotate step.
- cfg_update  in  1  one-cycle pulse from the register file on any register write.
- led_out  out  NUM_LEDS  registered LED drive.
- step_tick  out  1  one-cycle pulse on each blink/rotate step.
- state_o  out  2  current FSM state: 0 IDLE, 1 STATIC, 2 BLINK, 3 ROTATE.

Behaviour:
- Reset (ARESETN=0, asynchronous): all counters, shadows, the pending flag, phase, led_out, step_tick and state_o go to 0; FSM goes to IDLE.
- Shadow load:
  - cfg_update sets pending=1.
  - A load copies all four inputs into the shadow registers, reloads the work pattern from shadow pattern, sets phase=1, clears the step counter and clears pending.
  - In IDLE, a load occurs on the cycle after pending sets.
  - In a run state, a load occurs on the frame_end cycle if pending=1.
  - If cfg_update and frame_end coincide, the load uses the input values present on that cycle.
- Prescaler:
  - Effective P = max(P,1); pre_cnt counts 0..P-1.
  - pwm_tick=1 when pre_cnt==P-1, and pre_cnt then wraps to 0.
- PWM:
  - pwm_cnt increments on pwm_tick and wraps from 2^PWM_BITS-1 to 0.
  - frame_end = pwm_tick && pwm_cnt==2^PWM_BITS-1.
  - pwm_on = (pwm_cnt < duty) or (duty == 2^PWM_BITS-1), so maximum duty means always on.
- Step:
  - Effective S = max(S,1); step_cnt increments on frame_end.
  - On frame_end with step_cnt==S-1, step_cnt returns to 0 and step_tick pulses for 1 cycle.
  - No step_tick in IDLE or STATIC.
  - A step that coincides with a shadow load is suppressed; the load wins.
- FSM:
  - IDLE -> mode state on a load with shadow enable=1; mode 01 -> BLINK, 1x -> ROTATE.
  - Any run state -> IDLE on a load with enable=0.
  - Run state -> other run state on a load with a new mode.
  - IDLE counters are held at 0; counting starts the cycle after leaving IDLE.
- Work pattern:
  - BLINK: phase toggles on each step.
  - ROTATE: the pattern rotates by 1 bit per step, left for mode 10 and right for mode 11, with MSB<->LSB wrap.
- Output:
  - led_out <= (state!=IDLE) ? work_pattern & {NUM_LEDS{pwm_on}} & {NUM_LEDS{phase}} : 0.
  - led_out is registered, 1 ACLK latency from pwm_cnt/phase changes.
- Width rules: pattern, duty and prescale bits above the parameter widths are ignored; there is no saturation, only truncation.

Test Plan:
- Reset, then pulse cfg_update with ctrl=0x1, pattern=0xA5, duty=128, P=1, S=1 -> state_o=1 within 2 cycles; led_out=0xA5 for 128 cycles then 0x00 for 128 cycles, repeating every 256.
- ctrl=0x3 (blink), pattern=0xFF, duty=255, P=1, S=2 -> led_out 0xFF for 512 cycles, 0x00 for 512 cycles; step_tick pulses every 512 cycles.
- ctrl=0x5 (rotate-left), pattern=0x80, duty=255, P=0 (treated as 1), S=1 -> led_out sequence 0x80, 0x01, 0x02, one change per 256 cycles.
- Mode 11 run with pattern 0x01, then cfg_update with duty=32 mid-frame at pwm_cnt=100 -> old duty holds until frame_end; new duty visible on the first frame after; rotation restarts from the new pattern.
- Running blink, cfg_update with ctrl=0x0 -> led_out=0 and state_o=0 one cycle after the next frame_end.
- Assert ARESETN low mid-rotation for 3 cycles -> led_out=0, step_tick=0 and state_o=0 immediately (asynchronously); after release the block stays IDLE until a cfg_update.
